// File: rtl/nmea_pkg.sv
// nmea_pkg: shared FSM state, ASCII constants and char helpers
// for the RMC sentence parser.
package nmea_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      FIELD,
      CK_HI,
      CK_LO
   } nmea_st_e;

   localparam logic [7:0] ASC_DOLLAR = 8'h24;
   localparam logic [7:0] ASC_STAR   = 8'h2A;
   localparam logic [7:0] ASC_COMMA  = 8'h2C;
   localparam logic [7:0] ASC_A      = 8'h41;

   function automatic logic is_digit(input logic [7:0] c);
      return (c >= 8'h30) && (c <= 8'h39);
   endfunction

   // Returns {valid, nibble}; upper and lower case both accepted.
   function automatic logic [4:0] hex_nib(input logic [7:0] c);
      logic [4:0] r;
      r = 5'h00;
      unique case (1'b1)
         (c >= 8'h30 && c <= 8'h39): r = {1'b1, c[3:0]};
         (c >= 8'h41 && c <= 8'h46): r = {1'b1, c[3:0] + 4'd9};
         (c >= 8'h61 && c <= 8'h66): r = {1'b1, c[3:0] + 4'd9};
         default:                    r = 5'h00;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/nmea_rmc_parser_if.sv
// nmea_rmc_parser_if: UART byte stream into the parser,
// data qualified by a one-cycle flag.
interface nmea_rmc_parser_if;
   logic [7:0] po_data;
   logic       po_flag;

   modport master (
      output po_data,
      output po_flag
   );

   modport slave (
      input po_data,
      input po_flag
   );
endinterface

// File: rtl/nmea_tz_adj.sv
// nmea_tz_adj: combinational BCD hour offset with day wrap.
// Offset applied only when NMEA_TZ_EN is defined, else UTC passes.
module nmea_tz_adj
   import nmea_pkg::*;
#(
   parameter int TZ_OFFSET_H = 8
) (
   input  logic [7:0] hh_i,
   output logic [7:0] hh_o,
   output logic [1:0] day_o
);

   if ((TZ_OFFSET_H < -12) || (TZ_OFFSET_H > 14)) begin : g_bad_tz
      $error("TZ_OFFSET_H outside -12..14");
   end

`ifdef NMEA_TZ_EN
   int h;

   always_comb begin
      h     = int'(hh_i[7:4]) * 10 + int'(hh_i[3:0]);
      h     = h + TZ_OFFSET_H;
      day_o = 2'b00;
      if (h >= 24) begin
         h     = h - 24;
         day_o = 2'b01;
      end else if (h < 0) begin
         h     = h + 24;
         day_o = 2'b11;
      end
      hh_o = {4'(h / 10), 4'(h % 10)};
   end
`else
   assign hh_o  = hh_i;
   assign day_o = 2'b00;
`endif

endmodule

// File: rtl/nmea_rmc_parser.sv
// nmea_rmc_parser: extracts hhmmss and fix status from RMC sentences,
// checks the XOR checksum. Local-time offset gated by NMEA_TZ_EN.
module nmea_rmc_parser
   import nmea_pkg::*;
#(
   parameter logic [39:0] HDR_ID      = "GNRMC",
   parameter int          TZ_OFFSET_H = 8,
   parameter int          MAX_LEN     = 96
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   nmea_rmc_parser_if.slave rx,
   output logic [23:0]      time_bcd,
   output logic [1:0]       day_adj,
   output logic             fix_ok,
   output logic             time_vld,
   output logic             cks_err
);

   localparam int LW = $clog2(MAX_LEN + 1);

   nmea_st_e st_q, st_d;

   logic [7:0]    xor_q;
   logic [LW-1:0] len_q;
   logic [2:0]    hidx_q;
   logic [1:0]    fld_q;
   logic [2:0]    f1n_q;
   logic          tbad_q;
   logic [23:0]   tcap_q;
   logic          fchr_q;
   logic          fixc_q;
   logic [3:0]    ckh_q;
   logic          ckbad_q;
   logic [23:0]   time_q;
   logic [1:0]    day_q;
   logic          fix_q;
   logic          vld_q;
   logic          err_q;

   logic       restart, nd;
   logic       is_star, is_comma;
   logic       hdr_en, fld_en, ck_hi_en, ck_lo_en;
   logic       fld_tok, xor_en, len_en, len_max;
   logic [7:0] hdr_ch;
   logic [4:0] hn;
   logic       ck_ok, f1_ok;
   logic [7:0] tz_hh;
   logic [1:0] tz_day;

   assign restart  = rx.po_flag && (rx.po_data == ASC_DOLLAR);
   assign nd       = rx.po_flag && (rx.po_data != ASC_DOLLAR);
   assign is_star  = (rx.po_data == ASC_STAR);
   assign is_comma = (rx.po_data == ASC_COMMA);
   assign len_max  = (int'(len_q) + 1) >= MAX_LEN;
   assign hn       = hex_nib(rx.po_data);

   always_comb begin
      hdr_ch = 8'h00;
      unique case (hidx_q)
         3'd0:    hdr_ch = HDR_ID[39:32];
         3'd1:    hdr_ch = HDR_ID[31:24];
         3'd2:    hdr_ch = HDR_ID[23:16];
         3'd3:    hdr_ch = HDR_ID[15:8];
         3'd4:    hdr_ch = HDR_ID[7:0];
         default: hdr_ch = 8'h00;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) st_q <= IDLE;
      else         st_q <= st_d;
   end

   always_comb begin
      st_d = st_q;
      if (restart) begin
         st_d = HDR;
      end else if (nd) begin
         unique case (st_q)
            IDLE: st_d = IDLE;
            HDR: begin
               if (hidx_q < 3'd5) begin
                  if (rx.po_data != hdr_ch) st_d = IDLE;
               end else begin
                  st_d = is_comma ? FIELD : IDLE;
               end
            end
            FIELD: begin
               if (is_star)      st_d = CK_HI;
               else if (len_max) st_d = IDLE;
            end
            CK_HI:   st_d = CK_LO;
            CK_LO:   st_d = IDLE;
            default: st_d = IDLE;
         endcase
      end
   end

   always_comb begin
      hdr_en   = 1'b0;
      fld_en   = 1'b0;
      ck_hi_en = 1'b0;
      ck_lo_en = 1'b0;
      if (nd) begin
         unique case (st_q)
            HDR:     hdr_en   = 1'b1;
            FIELD:   fld_en   = 1'b1;
            CK_HI:   ck_hi_en = 1'b1;
            CK_LO:   ck_lo_en = 1'b1;
            default: ;
         endcase
      end
   end

   assign fld_tok = fld_en && !is_star;
   assign xor_en  = hdr_en || fld_tok;
   assign len_en  = hdr_en || fld_tok;

   // Low nibble arrives on the CK_LO byte itself.
   assign ck_ok = !ckbad_q && hn[4]
                && ({ckh_q, hn[3:0]} == xor_q);
   assign f1_ok = !tbad_q && (f1n_q == 3'd6);

   nmea_tz_adj #(
      .TZ_OFFSET_H (TZ_OFFSET_H)
   ) u_tz (
      .hh_i  (tcap_q[23:16]),
      .hh_o  (tz_hh),
      .day_o (tz_day)
   );

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         xor_q   <= 8'h00;
         len_q   <= '0;
         hidx_q  <= 3'd0;
         fld_q   <= 2'd0;
         f1n_q   <= 3'd0;
         tbad_q  <= 1'b0;
         tcap_q  <= 24'h000000;
         fchr_q  <= 1'b0;
         fixc_q  <= 1'b0;
         ckh_q   <= 4'h0;
         ckbad_q <= 1'b0;
         time_q  <= 24'h000000;
         day_q   <= 2'b00;
         fix_q   <= 1'b0;
         vld_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         vld_q <= 1'b0;
         err_q <= 1'b0;
         if (restart) begin
            xor_q   <= 8'h00;
            len_q   <= LW'(1);
            hidx_q  <= 3'd0;
            fld_q   <= 2'd1;
            f1n_q   <= 3'd0;
            tbad_q  <= 1'b0;
            tcap_q  <= 24'h000000;
            fchr_q  <= 1'b0;
            fixc_q  <= 1'b0;
            ckh_q   <= 4'h0;
            ckbad_q <= 1'b0;
         end else begin
            if (xor_en) xor_q <= xor_q ^ rx.po_data;
            if (len_en) len_q <= len_q + 1'b1;
            if (hdr_en) hidx_q <= hidx_q + 3'd1;
            if (fld_tok) begin
               if (is_comma) begin
                  if (fld_q != 2'd3) fld_q <= fld_q + 2'd1;
                  fchr_q <= 1'b0;
               end else begin
                  fchr_q <= 1'b1;
                  if (fld_q == 2'd1 && f1n_q < 3'd6) begin
                     tcap_q <= {tcap_q[19:0], rx.po_data[3:0]};
                     f1n_q  <= f1n_q + 3'd1;
                     if (!is_digit(rx.po_data)) tbad_q <= 1'b1;
                  end
                  if (fld_q == 2'd2 && !fchr_q) begin
                     fixc_q <= (rx.po_data == ASC_A);
                  end
               end
            end
            if (ck_hi_en) begin
               ckh_q   <= hn[3:0];
               ckbad_q <= !hn[4];
            end
            if (ck_lo_en) begin
               if (!ck_ok) begin
                  err_q <= 1'b1;
               end else if (f1_ok) begin
                  vld_q  <= 1'b1;
                  time_q <= {tz_hh, tcap_q[15:0]};
                  day_q  <= tz_day;
                  fix_q  <= fixc_q;
               end
            end
         end
      end
   end

   assign time_bcd = time_q;
   assign day_adj  = day_q;
   assign fix_ok   = fix_q;
   assign time_vld = vld_q;
   assign cks_err  = err_q;

endmodule

// File: tb/tb_nmea_rmc_parser.sv
// tb_nmea_rmc_parser: scoreboard bench for the RMC parser,
// expected pulses queued at send time and popped on DUT pulses.
module tb_nmea_rmc_parser;

`ifdef NMEA_TZ_EN
   localparam bit TZ_ON = 1'b1;
`else
   localparam bit TZ_ON = 1'b0;
`endif

   typedef struct packed {
      logic        err;
      logic [23:0] t;
      logic [1:0]  d;
      logic        f;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   nmea_rmc_parser_if rx_if ();

   logic [23:0] time_bcd, time2;
   logic [1:0]  day_adj, day2;
   logic        fix_ok, fix2;
   logic        time_vld, vld2;
   logic        cks_err, err2;

   nmea_rmc_parser #(.TZ_OFFSET_H(8)) dut (
      .sys_clk  (clk),
      .sys_rst  (rst),
      .rx       (rx_if),
      .time_bcd (time_bcd),
      .day_adj  (day_adj),
      .fix_ok   (fix_ok),
      .time_vld (time_vld),
      .cks_err  (cks_err)
   );

   nmea_rmc_parser #(.TZ_OFFSET_H(-5)) dut2 (
      .sys_clk  (clk),
      .sys_rst  (rst),
      .rx       (rx_if),
      .time_bcd (time2),
      .day_adj  (day2),
      .fix_ok   (fix2),
      .time_vld (vld2),
      .cks_err  (err2)
   );

   int   total = 0;
   int   bad   = 0;
   int   gap_max = 2;
   exp_t sb[$];
   exp_t mon_e;

   always @(negedge clk) begin
      if (!rst && (time_vld || cks_err)) begin
         total++;
         if (time_vld && cks_err) begin
            bad++;
            $display("FAIL both_pulses vld=%b err=%b want one", time_vld, cks_err);
         end else if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pulse vld=%b err=%b want none", time_vld, cks_err);
         end else begin
            mon_e = sb.pop_front();
            if (mon_e.err) begin
               if (!cks_err) begin
                  bad++;
                  $display("FAIL pulse_kind got vld want cks_err");
               end
            end else if (!time_vld) begin
               bad++;
               $display("FAIL pulse_kind got cks_err want time_vld");
            end else if (time_bcd !== mon_e.t || day_adj !== mon_e.d || fix_ok !== mon_e.f) begin
               bad++;
               $display("FAIL accept got t=%h d=%b f=%b want t=%h d=%b f=%b",
                        time_bcd, day_adj, fix_ok, mon_e.t, mon_e.d, mon_e.f);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic exp_t mk_vld(input int hh, input int mm, input int ss,
                                   input int ofs, input logic f);
      exp_t e;
      int   h;
      h   = hh;
      e.d = 2'b00;
      if (TZ_ON) begin
         h = hh + ofs;
         if (h > 23) begin
            h   = h - 24;
            e.d = 2'b01;
         end else if (h < 0) begin
            h   = h + 24;
            e.d = 2'b11;
         end
      end
      e.err = 1'b0;
      e.t   = {bcd(h), bcd(mm), bcd(ss)};
      e.f   = f;
      return e;
   endfunction

   function automatic exp_t mk_fix(input logic [23:0] t, input logic [1:0] d,
                                   input logic f);
      exp_t e;
      e.err = 1'b0;
      e.t   = t;
      e.d   = d;
      e.f   = f;
      return e;
   endfunction

   function automatic exp_t mk_err();
      exp_t e;
      e = '0;
      e.err = 1'b1;
      return e;
   endfunction

   function automatic string rmc(input string t, input string st);
      return {"GNRMC,", t, ".00,", st,
              ",4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W"};
   endfunction

   function automatic logic [7:0] xor_of(input string s);
      logic [7:0] x;
      x = 8'h00;
      for (int i = 0; i < s.len(); i++) x = x ^ s[i];
      return x;
   endfunction

   function automatic logic [7:0] hexc(input logic [3:0] n, input bit lower);
      if (n < 4'd10) return 8'h30 + 8'(n);
      return (lower ? 8'h61 : 8'h41) + 8'(n) - 8'd10;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      int g;
      rx_if.po_data = b;
      rx_if.po_flag = 1'b1;
      @(posedge clk);
      #1;
      rx_if.po_flag = 1'b0;
      rx_if.po_data = 8'h24;
      g = $urandom_range(0, gap_max);
      repeat (g) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   // mode 0 good upper, 1 good lower, 2 flipped sum, 3 "G1"
   task automatic send_sent(input string body, input int mode);
      logic [7:0] x;
      x = xor_of(body);
      if (mode == 2) x = x ^ 8'h01;
      send_byte(8'h24);
      send_str(body);
      send_byte(8'h2A);
      if (mode == 3) begin
         send_byte("G");
         send_byte("1");
      end else begin
         send_byte(hexc(x[7:4], mode == 1));
         send_byte(hexc(x[3:0], mode == 1));
      end
   endtask

   task automatic drain(input string name);
      repeat (4) @(posedge clk);
      #1;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain_%s got=%0d want=0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset;
      total++;
      if (time_bcd !== 24'h000000) begin
         bad++;
         $display("FAIL rst_time got=%h want=000000", time_bcd);
      end
      total++;
      if (day_adj !== 2'b00) begin
         bad++;
         $display("FAIL rst_day got=%b want=00", day_adj);
      end
      total++;
      if (fix_ok !== 1'b0) begin
         bad++;
         $display("FAIL rst_fix got=%b want=0", fix_ok);
      end
      total++;
      if (time_vld !== 1'b0 || cks_err !== 1'b0) begin
         bad++;
         $display("FAIL rst_pulses got=%b%b want=00", time_vld, cks_err);
      end
   endtask

   task automatic test_basic;
      logic [23:0] want;
      want = TZ_ON ? 24'h203519 : 24'h123519;
      sb.push_back(mk_fix(want, 2'b00, 1'b1));
      send_sent(rmc("123519", "A"), 0);
      drain("basic");
      total++;
      if (time_bcd !== want || fix_ok !== 1'b1) begin
         bad++;
         $display("FAIL basic_hold got=%h/%b want=%h/1", time_bcd, fix_ok, want);
      end
   endtask

   task automatic test_tz_wrap;
      sb.push_back(mk_fix(TZ_ON ? 24'h010000 : 24'h170000,
                          TZ_ON ? 2'b01 : 2'b00, 1'b1));
      send_sent(rmc("170000", "A"), 0);
      sb.push_back(mk_vld(23, 59, 59, 8, 1'b1));
      send_sent(rmc("235959", "A"), 0);
      sb.push_back(mk_vld(3, 0, 0, 8, 1'b1));
      send_sent(rmc("030000", "A"), 0);
      drain("tz_wrap");
      total++;
      if (time2 !== (TZ_ON ? 24'h220000 : 24'h030000)) begin
         bad++;
         $display("FAIL tz_neg_time got=%h want=%h", time2,
                  TZ_ON ? 24'h220000 : 24'h030000);
      end
      total++;
      if (day2 !== (TZ_ON ? 2'b11 : 2'b00)) begin
         bad++;
         $display("FAIL tz_neg_day got=%b want=%b", day2, TZ_ON ? 2'b11 : 2'b00);
      end
   endtask

   task automatic test_cks_err;
      logic [23:0] st;
      logic [1:0]  sd;
      logic        sf;
      st = time_bcd;
      sd = day_adj;
      sf = fix_ok;
      sb.push_back(mk_err());
      send_sent(rmc("111111", "V"), 2);
      sb.push_back(mk_err());
      send_sent(rmc("121212", "V"), 3);
      drain("cks_err");
      total++;
      if (time_bcd !== st || day_adj !== sd || fix_ok !== sf) begin
         bad++;
         $display("FAIL cks_hold got=%h/%b/%b want=%h/%b/%b",
                  time_bcd, day_adj, fix_ok, st, sd, sf);
      end
      sb.push_back(mk_vld(6, 45, 12, 8, 1'b1));
      send_sent(rmc("064512", "A"), 1);
      drain("cks_lower");
   endtask

   task automatic test_abort;
      logic [23:0] st;
      st = time_bcd;
      send_sent("GPGSV,3,1,11,07,79,048,42", 0);
      send_sent(rmc("101010", "A").substr(0, 4) == "GNRMC" ?
                {"GNRMX", rmc("101010", "A").substr(5, 70)} : "", 0);
      send_sent(rmc("12a519", "A"), 0);
      send_sent("GNRMC,1235,A,4807.038,N", 0);
      send_byte(8'h24);
      send_str("GNRMC,12");
      drain("abort_none");
      total++;
      if (time_bcd !== st) begin
         bad++;
         $display("FAIL abort_hold got=%h want=%h", time_bcd, st);
      end
      sb.push_back(mk_vld(8, 30, 0, 8, 1'b1));
      send_sent(rmc("083000", "A"), 0);
      drain("abort_next");
   endtask

   task automatic test_status;
      sb.push_back(mk_vld(10, 10, 10, 8, 1'b0));
      send_sent(rmc("101010", "V"), 0);
      drain("status_v");
      total++;
      if (fix_ok !== 1'b0) begin
         bad++;
         $display("FAIL status_v_fix got=%b want=0", fix_ok);
      end
      sb.push_back(mk_vld(1, 2, 3, 8, 1'b1));
      send_sent(rmc("010203", "A"), 0);
      sb.push_back(mk_vld(10, 10, 11, 8, 1'b0));
      send_sent(rmc("101011", ""), 0);
      drain("status_empty");
   endtask

   task automatic test_maxlen;
      string body;
      logic [23:0] st;
      st   = time_bcd;
      body = rmc("151515", "A");
      while (body.len() < 120) body = {body, ",X"};
      send_sent(body, 0);
      drain("maxlen");
      total++;
      if (time_bcd !== st) begin
         bad++;
         $display("FAIL maxlen_hold got=%h want=%h", time_bcd, st);
      end
      sb.push_back(mk_vld(15, 15, 16, 8, 1'b1));
      send_sent(rmc("151516", "A"), 0);
      drain("maxlen_next");
   endtask

   task automatic test_back_to_back;
      int hh, mm, ss;
      gap_max = 0;
      for (int i = 0; i < 6; i++) begin
         hh = $urandom_range(0, 23);
         mm = $urandom_range(0, 59);
         ss = $urandom_range(0, 59);
         sb.push_back(mk_vld(hh, mm, ss, 8, 1'(i % 2)));
         send_sent(rmc($sformatf("%02d%02d%02d", hh, mm, ss),
                       (i % 2) ? "A" : "V"), i % 2);
      end
      gap_max = 2;
      drain("b2b");
   endtask

   task automatic test_reset_mid;
      string body;
      body = rmc("090909", "A");
      send_byte(8'h24);
      send_str(body.substr(0, 19));
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      send_str(body.substr(20, body.len() - 1));
      send_byte(8'h2A);
      send_byte(hexc(xor_of(body) >> 4, 1'b0));
      send_byte(hexc(xor_of(body) & 8'h0F, 1'b0));
      drain("reset_mid");
      total++;
      if (time_bcd !== 24'h000000 || day_adj !== 2'b00 || fix_ok !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_out got=%h/%b/%b want=000000/00/0",
                  time_bcd, day_adj, fix_ok);
      end
   endtask

   initial begin
      rst           = 1'b1;
      rx_if.po_data = 8'h00;
      rx_if.po_flag = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      rst = 1'b0;
      @(posedge clk);
      #1;
      test_basic();
      test_tz_wrap();
      test_cks_err();
      test_abort();
      test_status();
      test_maxlen();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
